// File: rtl/alu_arbiter_pkg.sv
// Shared ALU definitions: opcode constants, legal-op check, arbiter FSM states.
package alu_arbiter_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // True when the opcode is one the ALU actually implements.
  function automatic logic op_legal(input logic [3:0] op);
    logic ok;
    ok = 1'b0;
    case (op)
      ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/alu_arbiter_rr.sv
// Two-way round-robin grant: sole requester wins, on contention the one that
// did not win last time wins.
module rr_arbiter2 (
  input  logic [1:0] valid,
  input  logic       last,
  output logic [1:0] gnt
);

  // One-hot grant, pure combinational.
  always_comb begin
    gnt    = '0;
    gnt[0] = valid[0] & (~valid[1] | last);
    gnt[1] = valid[1] & (~valid[0] | ~last);
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two valid/ready requesters.
// One operation in flight: IDLE (accept) -> EXEC (ALU evaluates) -> RESP.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int NBITS = 32,
  parameter int BOP   = 4
) (
  input  logic             i_Clk,
  input  logic             i_Reset_n,
  input  logic             i_ReqValid0,
  output logic             o_ReqReady0,
  input  logic [NBITS-1:0] i_ReqA0,
  input  logic [NBITS-1:0] i_ReqB0,
  input  logic [BOP-1:0]   i_ReqOp0,
  output logic             o_RespValid0,
  input  logic             i_RespReady0,
  output logic [NBITS-1:0] o_RespResult0,
  output logic             o_RespCero0,
  output logic             o_RespErr0,
  input  logic             i_ReqValid1,
  output logic             o_ReqReady1,
  input  logic [NBITS-1:0] i_ReqA1,
  input  logic [NBITS-1:0] i_ReqB1,
  input  logic [BOP-1:0]   i_ReqOp1,
  output logic             o_RespValid1,
  input  logic             i_RespReady1,
  output logic [NBITS-1:0] o_RespResult1,
  output logic             o_RespCero1,
  output logic             o_RespErr1,
  output logic [NBITS-1:0] o_AluA,
  output logic [NBITS-1:0] o_AluB,
  output logic [BOP-1:0]   o_AluOp,
  input  logic [NBITS-1:0] i_AluResult,
  input  logic             i_AluCero
);

  typedef struct packed {
    logic [NBITS-1:0] a;
    logic [NBITS-1:0] b;
    logic [BOP-1:0]   op;
  } req_t;

  state_t                  state, state_nxt;
  logic                    last;
  logic                    lat_id;
  req_t                    lat, req_sel;
  logic [1:0]              req_vld, resp_rdy, gnt, acc;
  logic [1:0][NBITS-1:0]   resp_res;
  logic [1:0]              resp_cero, resp_err;

  assign req_vld  = {i_ReqValid1, i_ReqValid0};
  assign resp_rdy = {i_RespReady1, i_RespReady0};

  rr_arbiter2 u_rr (
    .valid (req_vld),
    .last  (last),
    .gnt   (gnt)
  );

  // Winner's payload; only consumed on an accepted handshake.
  always_comb begin
    req_sel    = '0;
    req_sel.a  = gnt[1] ? i_ReqA1  : i_ReqA0;
    req_sel.b  = gnt[1] ? i_ReqB1  : i_ReqB0;
    req_sel.op = gnt[1] ? i_ReqOp1 : i_ReqOp0;
  end

  // Next state; request readies only exist in IDLE.
  always_comb begin
    state_nxt = state;
    acc       = '0;
    case (state)
      ST_IDLE: begin
        acc = gnt;
        if (|gnt) state_nxt = ST_EXEC;
      end
      ST_EXEC: state_nxt = ST_RESP;
      ST_RESP: if (resp_rdy[lat_id]) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) state <= ST_IDLE;
    else            state <= state_nxt;
  end

  // Latch the accepted request; these registers drive the ALU directly so
  // request-port activity never reaches it between accepts.
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      lat    <= '0;
      lat_id <= 1'b0;
      last   <= 1'b1;
    end else if (|acc) begin
      lat    <= req_sel;
      lat_id <= gnt[1];
      last   <= gnt[1];
    end
  end

  // Capture ALU outputs into the winner's response slot; the other slot holds.
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      resp_res  <= '0;
      resp_cero <= '0;
      resp_err  <= '0;
    end else if (state == ST_EXEC) begin
      resp_res[lat_id]  <= i_AluResult;
      resp_cero[lat_id] <= i_AluCero;
      resp_err[lat_id]  <= ~op_legal(4'(lat.op));
    end
  end

  assign o_ReqReady0   = acc[0];
  assign o_ReqReady1   = acc[1];
  assign o_RespValid0  = (state == ST_RESP) && !lat_id;
  assign o_RespValid1  = (state == ST_RESP) &&  lat_id;
  assign o_RespResult0 = resp_res[0];
  assign o_RespResult1 = resp_res[1];
  assign o_RespCero0   = resp_cero[0];
  assign o_RespCero1   = resp_cero[1];
  assign o_RespErr0    = resp_err[0];
  assign o_RespErr1    = resp_err[1];
  assign o_AluA        = lat.a;
  assign o_AluB        = lat.b;
  assign o_AluOp       = lat.op;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench: drivers issue requests, the monitor predicts grants and
// responses from a behavioural ALU/round-robin model and checks the DUT.
module tb_alu_arbiter;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
  } op_t;

  typedef struct packed {
    logic        id;
    logic [31:0] res;
    logic        cero;
    logic        err;
    logic [31:0] acc;
  } exp_t;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        vld0 = 1'b0, vld1 = 1'b0, rdy0 = 1'b1, rdy1 = 1'b1;
  logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic [3:0]  op0 = '0, op1 = '0;
  logic        o_ReqReady0, o_ReqReady1, o_RespValid0, o_RespValid1;
  logic [31:0] o_RespResult0, o_RespResult1, o_AluA, o_AluB, alu_res;
  logic        o_RespCero0, o_RespCero1, o_RespErr0, o_RespErr1, alu_cero;
  logic [3:0]  o_AluOp;

  op_t  s0[$], s1[$];
  exp_t eq[$];
  exp_t e;
  int   vectors = 0, miscompares = 0, cyc = 0;
  int   mode0 = 0, mode1 = 0;  // 0 always ready, 1 random, 2 stalled
  logic last_m = 1'b1, first_seen = 1'b0, w, ew;
  logic [31:0] hold_res[2];
  logic        hold_cero[2], hold_err[2];
  logic [3:0]  legal_ops[6] = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'hC};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_arbiter #(.NBITS(32), .BOP(4)) dut (
    .i_Clk(clk), .i_Reset_n(rst_n),
    .i_ReqValid0(vld0), .o_ReqReady0(o_ReqReady0), .i_ReqA0(a0), .i_ReqB0(b0), .i_ReqOp0(op0),
    .o_RespValid0(o_RespValid0), .i_RespReady0(rdy0), .o_RespResult0(o_RespResult0),
    .o_RespCero0(o_RespCero0), .o_RespErr0(o_RespErr0),
    .i_ReqValid1(vld1), .o_ReqReady1(o_ReqReady1), .i_ReqA1(a1), .i_ReqB1(b1), .i_ReqOp1(op1),
    .o_RespValid1(o_RespValid1), .i_RespReady1(rdy1), .o_RespResult1(o_RespResult1),
    .o_RespCero1(o_RespCero1), .o_RespErr1(o_RespErr1),
    .o_AluA(o_AluA), .o_AluB(o_AluB), .o_AluOp(o_AluOp),
    .i_AluResult(alu_res), .i_AluCero(alu_cero)
  );

  // Behavioural ALU: MIPS-style op set, unknown ops give all ones.
  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    case (op)
      4'h0:    return a & b;
      4'h1:    return a | b;
      4'h2:    return a + b;
      4'h6:    return a - b;
      4'h7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'hC:    return ~(a | b);
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic logic legal_f(input logic [3:0] op);
    return op inside {4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'hC};
  endfunction

  function automatic op_t mk(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    op_t t;
    t.a = a; t.b = b; t.op = op;
    return t;
  endfunction

  function automatic logic pick(input int m);
    if (m == 0) return 1'b1;
    if (m == 2) return 1'b0;
    return 1'($urandom_range(0, 1));
  endfunction

  assign alu_res  = alu_f(o_AluA, o_AluB, o_AluOp);
  assign alu_cero = (alu_res == 32'd0);

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Drivers: hold valid and payload until the handshake, then load the next op.
  initial begin
    logic hs0, hs1;
    op_t  t;
    forever begin
      @(negedge clk);
      hs0 = vld0 && o_ReqReady0;
      hs1 = vld1 && o_ReqReady1;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        vld0 = 1'b0; vld1 = 1'b0;
      end else begin
        if (!vld0 || hs0) begin
          if (s0.size() > 0) begin t = s0.pop_front(); a0 = t.a; b0 = t.b; op0 = t.op; vld0 = 1'b1; end
          else vld0 = 1'b0;
        end
        if (!vld1 || hs1) begin
          if (s1.size() > 0) begin t = s1.pop_front(); a1 = t.a; b1 = t.b; op1 = t.op; vld1 = 1'b1; end
          else vld1 = 1'b0;
        end
      end
      rdy0 = pick(mode0);
      rdy1 = pick(mode1);
    end
  end

  // Monitor: predict grant on each accept, check responses against the queue.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("ready_excl", 64'(o_ReqReady0 & o_ReqReady1), 64'd0);
      if (o_ReqReady0 | o_ReqReady1) begin
        w  = o_ReqReady1;
        ew = (vld0 && vld1) ? ~last_m : vld1;
        chk("grant", 64'(w), 64'(ew));
        chk("ready_without_valid", 64'((o_ReqReady0 & ~vld0) | (o_ReqReady1 & ~vld1)), 64'd0);
        e.id   = w;
        e.res  = w ? alu_f(a1, b1, op1) : alu_f(a0, b0, op0);
        e.cero = (e.res == 32'd0);
        e.err  = w ? ~legal_f(op1) : ~legal_f(op0);
        e.acc  = 32'(cyc);
        eq.push_back(e);
        last_m = w;
      end
      chk("resp_excl", 64'(o_RespValid0 & o_RespValid1), 64'd0);
      if (o_RespValid0 | o_RespValid1) begin
        w = o_RespValid1;
        chk("ready_during_resp", 64'(o_ReqReady0 | o_ReqReady1), 64'd0);
        if (eq.size() == 0) chk("resp_unexpected", 64'({o_RespValid1, o_RespValid0}), 64'd0);
        else begin
          e = eq[0];
          chk("resp_id", 64'(w), 64'(e.id));
          chk("resp_result", 64'(w ? o_RespResult1 : o_RespResult0), 64'(e.res));
          chk("resp_cero", 64'(w ? o_RespCero1 : o_RespCero0), 64'(e.cero));
          chk("resp_err", 64'(w ? o_RespErr1 : o_RespErr0), 64'(e.err));
          chk("other_hold_result", 64'(w ? o_RespResult0 : o_RespResult1), 64'(hold_res[~w]));
          chk("other_hold_flags", 64'(w ? {o_RespCero0, o_RespErr0} : {o_RespCero1, o_RespErr1}),
              64'({hold_cero[~w], hold_err[~w]}));
          if (!first_seen) begin
            chk("latency", 64'(cyc), 64'(e.acc + 32'd2));
            first_seen = 1'b1;
          end
          if (w ? rdy1 : rdy0) begin
            void'(eq.pop_front());
            hold_res[w]  = e.res;
            hold_cero[w] = e.cero;
            hold_err[w]  = e.err;
            first_seen   = 1'b0;
          end
        end
      end
    end
  end

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((s0.size() + s1.size() + eq.size() > 0 || vld0 || vld1) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(eq.size() + s0.size() + s1.size()) + 64'(vld0) + 64'(vld1), 64'd0);
  endtask

  task automatic wait_resp(input logic id, input int budget);
    int n = 0;
    @(negedge clk);
    while (!(id ? o_RespValid1 : o_RespValid0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("wait_resp", 64'(id ? o_RespValid1 : o_RespValid0), 64'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_valids_readys"}, 64'({o_RespValid0, o_RespValid1, o_ReqReady0, o_ReqReady1}), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin hold_res[i] = '0; hold_cero[i] = 1'b0; hold_err[i] = 1'b0; end
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    chk("reset_alu", {o_AluA, o_AluB} | 64'(o_AluOp), 64'd0);
    chk("reset_resp", {o_RespResult0, o_RespResult1}, 64'd0);
    chk("reset_flags", 64'({o_RespCero0, o_RespErr0, o_RespCero1, o_RespErr1}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Both valid continuously: grants alternate starting with requester 0.
    for (int i = 0; i < 6; i++) begin
      s0.push_back(mk(32'(i), 32'd1, 4'h2));
      s1.push_back(mk(32'(i), 32'd100, 4'h2));
    end
    wait_idle(200);

    // Single requester ADD, SLT both ways, illegal opcode.
    s0.push_back(mk(32'd5, 32'd7, 4'h2));
    s0.push_back(mk(32'd2, 32'd9, 4'h7));
    s0.push_back(mk(32'd9, 32'd2, 4'h7));
    s0.push_back(mk(32'h1234, 32'd5, 4'h3));
    wait_idle(100);

    // SUB to zero, response stalled while requester 0 waits.
    mode1 = 2;
    s1.push_back(mk(32'd3, 32'd3, 4'h6));
    wait_resp(1'b1, 20);
    s0.push_back(mk(32'd8, 32'd8, 4'h2));
    repeat (5) begin
      @(negedge clk);
      chk("stall_ready", 64'({o_ReqReady0, o_ReqReady1}), 64'd0);
    end
    mode1 = 0;
    wait_idle(100);

    // Reset during RESP aborts; afterwards requester 0 wins first.
    mode0 = 2;
    s0.push_back(mk(32'd1, 32'd2, 4'h2));
    wait_resp(1'b0, 20);
    #1 rst_n = 1'b0;
    #1 check_idle_outputs("async_reset");
    eq.delete(); s0.delete(); s1.delete();
    first_seen = 1'b0; last_m = 1'b1; mode0 = 0;
    for (int i = 0; i < 2; i++) begin hold_res[i] = '0; hold_cero[i] = 1'b0; hold_err[i] = 1'b0; end
    repeat (2) @(posedge clk);
    s0.push_back(mk(32'd10, 32'd20, 4'h2));
    s1.push_back(mk(32'd30, 32'd40, 4'h1));
    @(posedge clk);
    #3 rst_n = 1'b1;
    wait_idle(100);

    // Randomized traffic with random response backpressure.
    mode0 = 1; mode1 = 1;
    for (int k = 0; k < 300; k++) begin
      logic [31:0] ra, rb;
      logic [3:0]  rop;
      ra  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      rop = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : legal_ops[$urandom_range(0, 5)];
      if ($urandom_range(0, 1) == 1) s1.push_back(mk(ra, rb, rop));
      else                           s0.push_back(mk(ra, rb, rop));
    end
    wait_idle(20000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares one combinational ALU between two requesters, e.g. the EX-stage datapath and a debug/unit-test port. Each requester uses its own valid/ready handshake.
- Requests are granted round-robin and operands are registered before they drive the ALU.
- The ALU result and zero flag are captured and returned to the granted requester.
- Opcodes outside the legal set are flagged.

Parameters:
NBITS, 32, operand/result width
BOP, 4, ALU opcode width

Ports:
i_Clk  in  1  clock, all state on rising edge
i_Reset_n  in  1  asynchronous, active-low reset
i_ReqValid0  in  1  requester 0 has an operation
o_ReqReady0  out  1  requester 0 request accepted this cycle
i_ReqA0  in  NBITS  operand A, requester 0
i_ReqB0  in  NBITS  operand B, requester 0
i_ReqOp0  in  BOP  ALU opcode, requester 0
o_RespValid0  out  1  response for requester 0 available
i_RespReady0  in  1  requester 0 consumes response
o_RespResult0  out  NBITS  result to requester 0
o_RespCero0  out  1  zero flag to requester 0
o_RespErr0  out  1  illegal opcode flag to requester 0
i_ReqValid1, o_ReqReady1, i_ReqA1, i_ReqB1, i_ReqOp1  same as above, requester 1
o_RespValid1, i_RespReady1, o_RespResult1, o_RespCero1, o_RespErr1  same as above, requester 1
o_AluA  out  NBITS  to ALU operand A (i_Reg side)
o_AluB  out  NBITS  to ALU operand B (i_Mux side)
o_AluOp  out  BOP  to ALU opcode
i_AluResult  in  NBITS  from ALU result
i_AluCero  in  1  from ALU zero flag

Behaviour:
- Reset is asynchronous and active-low; clock i_Clk, reset i_Reset_n.
- Reset values: state IDLE, all o_RespValid*/o_ReqReady*/o_RespErr*/o_RespCero* = 0; o_RespResult*, o_AluA/B/Op = 0; priority pointer last = 1, so requester 0 wins first.
- States:
  - IDLE: if any i_ReqValid is high, the winner's ready is asserted combinationally.
    - Winner = the only valid requester, or, if both are valid, the one != last.
    - The handshake completes this cycle (T). Latch A/B/Op and winner id, set last = winner, go to EXEC.
  - EXEC (T+1): o_AluA/B/Op are driven from the latched registers. At the clock edge, capture i_AluResult, i_AluCero and err = (latched op not in {0000,0001,0010,0110,0111,1100}). Go to RESP.
  - RESP (T+2 onward): only the winner's o_RespValid is high, with result, cero and err held stable. When that requester's i_RespReady is high, the response completes; go to IDLE.
- Latency: accept at T, o_RespValid at T+2. Peak throughput is one operation per 3 cycles.
- o_ReqReady0/1 are 0 outside IDLE. Both are never high together.
- o_RespValid is never high for the non-winner. The non-winner's response outputs hold their previous values.
- Outside EXEC, o_AluA/B/Op hold the last latched values; no glitches reach the ALU from the request ports.
- An illegal opcode is not blocked. The ALU's all-ones result is returned with err = 1.
- A request presented during EXEC/RESP waits; the requester must hold valid and payload stable until ready.
- Reset mid-operation aborts the operation. The response is lost and no valid is asserted after reset deasserts.
- Arithmetic is entirely inside the ALU; the block adds no width conversion.

Decomposition:
- Shared package/include alu_defs: the six ALU opcode constants (AND, OR, ADD, SUB, SLT, NOR) and the legal-op check function. The ALU and this block both use it.
- Local constants: state encodings IDLE/EXEC/RESP (2 bits).
- One natural sub-module: rr_arbiter2, a combinational 2-way round-robin grant from valid[1:0] and the last pointer.

Test Plan:
1. Req0 ADD 5 + 7, RespReady0 = 1 -> ReqReady0 at T, RespValid0 at T+2, result 12, cero 0, err 0; RespValid1 stays 0.
2. Both valid continuously, each with ADD, ops per requester (0: i+1, 1: i+100) -> grants strictly alternate 0,1,0,1 starting with 0; every response routed to the correct requester.
3. Req1 SUB 3 - 3 -> result 0, cero 1. Then RespReady1 held low 5 cycles -> RespValid1 and result stable, both ReqReady 0, while Req0 is valid and waiting.
4. Req0 opcode 4'b0011 -> result 0xFFFFFFFF, err 1, cero 0.
5. Reset asserted during RESP -> all valids/readys 0 asynchronously. After release, with both valid, requester 0 is granted first.
6. Req0 SLT 2 < 9 -> result 1, cero 0. Req0 SLT 9 < 2 -> result 0, cero 1.
